// File: rtl/rf_dump_reader_pkg.sv
// Shared CPU definitions used by the register-file dump reader:
// register index width, default data width and dump FSM state encoding.
package rf_dump_reader_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/rf_dump_reader.sv
// Streams a contiguous (wrapping) range of register-file entries out through a
// valid/ready port, one word per two cycles, via a dedicated read port.
module rf_dump_reader
    import rf_dump_reader_pkg::*;
#(
    parameter int unsigned DATA_W  = XLEN,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [REG_IDX_W-1:0] first_idx,
    input  logic [REG_IDX_W-1:0] last_idx,
    output logic [REG_IDX_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_IDX_W-1:0] out_idx,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    dump_state_e          r_state;
    dump_state_e          w_state_next;
    logic [REG_IDX_W-1:0] r_cur_idx;
    logic [REG_IDX_W-1:0] r_last_idx;
    logic [REG_IDX_W-1:0] r_out_idx;
    logic [DATA_W-1:0]    r_out_data;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_advance;
    logic [DATA_W-1:0]    w_cap_data;

    // Next-state decode; abort overrides everything except reset.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_capture    = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (out_ready) begin
                    if (r_cur_idx == r_last_idx) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_cap_data = (ZERO_R0 && (r_cur_idx == '0)) ? '0 : rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath plus status outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_idx   <= '0;
            r_last_idx  <= '0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur_idx  <= first_idx;
                r_last_idx <= last_idx;
            end else if (w_advance) begin
                r_cur_idx <= r_cur_idx + REG_IDX_W'(1);
            end
            if (w_capture) begin
                r_out_idx  <= r_cur_idx;
                r_out_data <= w_cap_data;
            end
            r_out_valid <= (w_state_next == ST_SEND);
            r_out_last  <= (w_state_next == ST_SEND) && (r_cur_idx == r_last_idx);
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= (w_state_next == ST_DONE);
        end
    end

    assign rd_addr   = r_cur_idx;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: a word-queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int done_count = 0;

    typedef struct {
        logic [4:0] idx;
        bit         last;
    } word_t;

    word_t exp_q[$];
    bit    m_active = 1'b0;
    bit    m_done   = 1'b0;
    int    m_wait   = 0;

    rf_dump_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_data(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : regs[idx];
    endfunction

    // Reference model: a dump is the ordered list of indices first..last (mod 32),
    // each word appearing two cycles after start or after the previous handshake.
    always @(negedge clk) begin
        bit exp_valid;
        if (rst) begin
            exp_q.delete();
            m_active = 1'b0;
            m_done   = 1'b0;
            m_wait   = 0;
        end else begin
            if (m_wait > 0) m_wait--;
            exp_valid = m_active && (m_wait == 0) && (exp_q.size() > 0);
            chk("busy", 64'(busy), 64'(m_active));
            chk("done", 64'(done), 64'(m_done));
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid && out_valid) begin
                chk("out_idx", 64'(out_idx), 64'(exp_q[0].idx));
                chk("out_data", 64'(out_data), 64'(model_data(exp_q[0].idx)));
                chk("out_last", 64'(out_last), 64'(exp_q[0].last));
            end else begin
                chk("out_last_idle", 64'(out_last), 64'd0);
            end
            if (done) done_count++;

            if (abort) begin
                if (m_active) begin
                    exp_q.delete();
                    m_active = 1'b0;
                    m_done   = 1'b0;
                    m_wait   = 0;
                end
            end else if (m_done) begin
                m_done   = 1'b0;
                m_active = 1'b0;
            end else if (!m_active && start) begin
                int n;
                n = ((int'(last_idx) - int'(first_idx) + 32) % 32) + 1;
                for (int k = 0; k < n; k++) begin
                    word_t w;
                    w.idx  = 5'((int'(first_idx) + k) % 32);
                    w.last = (k == n - 1);
                    exp_q.push_back(w);
                end
                m_active = 1'b1;
                m_wait   = 2;
            end else if (exp_valid && out_ready) begin
                word_t w;
                w = exp_q.pop_front();
                hs_count++;
                if (w.last) m_done = 1'b1;
                else        m_wait = 2;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic wait_word(input string name, input logic [4:0] idx, input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (out_valid && out_idx == idx) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    initial begin
        int hs0;
        int dn0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h11111111 * 32'(i);
        regs[0]   = 32'hFFFFFFFF;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        first_idx = 5'd0;
        last_idx  = 5'd0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_idx", 64'(out_idx), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_rdaddr", 64'(rd_addr), 64'd0);
        rst = 1'b0;
        step();

        // Two-word dump, literal timing
        pulse_start(5'd1, 5'd2);
        chk("t1_read_valid", 64'(out_valid), 64'd0);
        chk("t1_read_busy", 64'(busy), 64'd1);
        chk("t1_rdaddr", 64'(rd_addr), 64'd1);
        step();
        chk("t1_w0_valid", 64'(out_valid), 64'd1);
        chk("t1_w0_idx", 64'(out_idx), 64'd1);
        chk("t1_w0_data", 64'(out_data), 64'h11111111);
        chk("t1_w0_last", 64'(out_last), 64'd0);
        step();
        chk("t1_gap_valid", 64'(out_valid), 64'd0);
        step();
        chk("t1_w1_idx", 64'(out_idx), 64'd2);
        chk("t1_w1_data", 64'(out_data), 64'h22222222);
        chk("t1_w1_last", 64'(out_last), 64'd1);
        step();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_done_busy", 64'(busy), 64'd1);
        step();
        chk("t1_after_done", 64'(done), 64'd0);
        chk("t1_after_busy", 64'(busy), 64'd0);

        // Wrap-around 30..1
        hs0 = hs_count; dn0 = done_count;
        pulse_start(5'd30, 5'd1);
        wait_idle("t2_idle", 40);
        chk("t2_words", 64'(hs_count - hs0), 64'd4);
        chk("t2_dones", 64'(done_count - dn0), 64'd1);

        // Backpressure hold for five cycles
        out_ready = 1'b0;
        pulse_start(5'd3, 5'd4);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_idx", 64'(out_idx), 64'd3);
            chk("t3_hold_data", 64'(out_data), 64'h33333333);
            step();
        end
        out_ready = 1'b1;
        wait_idle("t3_idle", 20);

        // Full 32-word dump with random backpressure
        hs0 = hs_count;
        pulse_start(5'd10, 5'd9);
        for (int i = 0; i < 400 && busy; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        out_ready = 1'b1;
        wait_idle("t4_idle", 10);
        chk("t4_words", 64'(hs_count - hs0), 64'd32);

        // Abort on the second word, then restart
        dn0 = done_count;
        pulse_start(5'd8, 5'd11);
        wait_word("t5_second", 5'd9, 20);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_busy", 64'(busy), 64'd0);
        chk("t5_abort_valid", 64'(out_valid), 64'd0);
        step();
        chk("t5_no_done", 64'(done_count - dn0), 64'd0);
        abort = 1'b1;
        pulse_start(5'd7, 5'd7);
        abort = 1'b0;
        chk("t5_abort_start", 64'(busy), 64'd0);
        pulse_start(5'd15, 5'd15);
        step();
        chk("t5_single_idx", 64'(out_idx), 64'd15);
        chk("t5_single_last", 64'(out_last), 64'd1);
        wait_idle("t5_idle", 10);

        // Write landing in the READ cycle, ignored start mid-dump
        pulse_start(5'd4, 5'd6);
        wait_word("t6_w4", 5'd4, 10);
        step();
        regs[5] = 32'hDEADBEEF;
        pulse_start(5'd20, 5'd20);
        chk("t6_data", 64'(out_data), 64'hDEADBEEF);
        chk("t6_idx", 64'(out_idx), 64'd5);
        wait_idle("t6_idle", 20);

        // Reset during SEND
        out_ready = 1'b0;
        pulse_start(5'd0, 5'd3);
        step();
        chk("t7_r0_zero", 64'(out_data), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_valid", 64'(out_valid), 64'd0);
        chk("t7_idx", 64'(out_idx), 64'd0);
        chk("t7_data", 64'(out_data), 64'd0);
        chk("t7_last", 64'(out_last), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_rdaddr", 64'(rd_addr), 64'd0);
        step();
        chk("t7_done", 64'(done), 64'd0);
        out_ready = 1'b1;
        step();
        chk("total_dones", 64'(done_count), 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
